// File: rtl/simon_round_ctrl_if.sv
// Handshake/status bundle between the Simon round controller and its user.
// The abort line exists only when SIMON_ROUND_ABORT_EN is defined.
interface simon_round_ctrl_if #(
  parameter int IDX_W = 6
);
  logic             start;
  logic             done_ready;
  logic             busy;
  logic             load_en;
  logic             round_en;
  logic             key_sched_en;
  logic [IDX_W-1:0] round_idx;
  logic             z_bit;
  logic             done_valid;
`ifdef SIMON_ROUND_ABORT_EN
  logic             abort;
`endif

  modport master (
`ifdef SIMON_ROUND_ABORT_EN
    output abort,
`endif
    output start, done_ready,
    input  busy, load_en, round_en, key_sched_en, round_idx, z_bit, done_valid
  );

  modport slave (
`ifdef SIMON_ROUND_ABORT_EN
    input  abort,
`endif
    input  start, done_ready,
    output busy, load_en, round_en, key_sched_en, round_idx, z_bit, done_valid
  );
endinterface

// File: rtl/simon_round_ctrl.sv
// Moore sequencer for an iterative Simon block cipher: load, ROUNDS rounds, hold result.
// Optional feature: define SIMON_ROUND_ABORT_EN to add an abort input that cancels a run.
module simon_round_ctrl #(
  parameter int          ROUNDS    = 32,
  parameter int          KEY_WORDS = 4,
  parameter int          IDX_W     = 6,
  parameter logic [61:0] Z_SEQ     = 62'b11111010001001010110000111001101111101000100101011000011100110
) (
  input logic               clk,
  input logic               reset,
  simon_round_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  logic [1:0]       state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             abort_hit;

`ifdef SIMON_ROUND_ABORT_EN
  assign abort_hit = bus.abort;
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        idx_next = '0;
        if (bus.start) state_next = LOAD;
      end
      LOAD: begin
        idx_next   = '0;
        state_next = ROUND;
      end
      ROUND: begin
        if (idx_reg == LAST_IDX) state_next = DONE;
        else                     idx_next   = idx_reg + 1'b1;
      end
      DONE: begin
        if (bus.done_ready) begin
          state_next = IDLE;
          idx_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
    // Abort overrides every other transition but has nothing to cancel in IDLE.
    if (abort_hit && state_reg != IDLE) begin
      state_next = IDLE;
      idx_next   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // Bit-reversed copy of the z constant so round r reads entry r directly.
  logic [61:0] z_rev;
  genvar gi;
  generate
    for (gi = 0; gi < 62; gi++) begin : g_zrev
      assign z_rev[gi] = Z_SEQ[61-gi];
    end
  endgenerate

  logic [5:0] z_sel;
  assign z_sel = 6'(32'(idx_reg) % 32'd62);

  assign bus.busy         = (state_reg != IDLE);
  assign bus.load_en      = (state_reg == LOAD);
  assign bus.round_en     = (state_reg == ROUND);
  assign bus.key_sched_en = (state_reg == ROUND) && (32'(idx_reg) >= 32'(KEY_WORDS));
  assign bus.z_bit        = (state_reg == ROUND) && z_rev[z_sel];
  assign bus.done_valid   = (state_reg == DONE);
  assign bus.round_idx    = idx_reg;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Directed bench for simon_round_ctrl: default 32-round instance plus a 72-round one for z wrap.
module tb_simon_round_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  simon_round_ctrl_if #(.IDX_W(6)) ia ();
  simon_round_ctrl_if #(.IDX_W(7)) ib ();

  simon_round_ctrl dut_a (.clk(clk), .reset(reset), .bus(ia));
  simon_round_ctrl #(.ROUNDS(72), .IDX_W(7)) dut_b (.clk(clk), .reset(reset), .bus(ib));

  int total = 0;
  int bad = 0;
  logic [61:0] zseq = 62'b11111010001001010110000111001101111101000100101011000011100110;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, ia.busy, 0);
    check_val({tag, "_load"}, ia.load_en, 0);
    check_val({tag, "_round"}, ia.round_en, 0);
    check_val({tag, "_key"}, ia.key_sched_en, 0);
    check_val({tag, "_z"}, ia.z_bit, 0);
    check_val({tag, "_done"}, ia.done_valid, 0);
    check_val({tag, "_idx"}, ia.round_idx, 0);
  endtask

  initial begin
    logic zexp;
    int   loads;
    int   rcount;
    logic seen_done;

    ia.start = 0; ia.done_ready = 0;
    ib.start = 0; ib.done_ready = 0;
`ifdef SIMON_ROUND_ABORT_EN
    ia.abort = 0; ib.abort = 0;
`endif
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    reset = 0;

    // Basic run, start accepted at the first edge after reset release.
    ia.start = 1;
    tick();
    check_val("load_en", ia.load_en, 1);
    check_val("load_busy", ia.busy, 1);
    check_val("load_round_en", ia.round_en, 0);
    check_val("load_idx", ia.round_idx, 0);
    ia.start = 0;
    for (int r = 0; r < 32; r++) begin
      tick();
      zexp = zseq[61 - (r % 62)];
      check_val("run_round_en", ia.round_en, 1);
      check_val("run_idx", ia.round_idx, r);
      check_val("run_load_en", ia.load_en, 0);
      check_val("run_key", ia.key_sched_en, (r >= 4) ? 1 : 0);
      check_val("run_z", ia.z_bit, zexp);
      check_val("run_done", ia.done_valid, 0);
    end
    tick();
    check_val("done_valid", ia.done_valid, 1);
    check_val("done_round_en", ia.round_en, 0);
    check_val("done_idx", ia.round_idx, 31);
    check_val("done_z", ia.z_bit, 0);
    $display("basic run: 32 rounds sequenced");

    // Backpressure.
    for (int c = 0; c < 10; c++) begin
      tick();
      check_val("hold_done", ia.done_valid, 1);
      check_val("hold_idx", ia.round_idx, 31);
    end
    ia.done_ready = 1;
    tick();
    check_val("ack_busy", ia.busy, 0);
    check_val("ack_done", ia.done_valid, 0);
    check_val("ack_idx", ia.round_idx, 0);
    ia.done_ready = 0;
    $display("backpressure: done held 10 cycles then released");

    // Start held high for the whole run and through the handshake.
    ia.start = 1;
    loads = 0;
    seen_done = 0;
    for (int c = 0; c < 60 && !seen_done; c++) begin
      tick();
      if (ia.load_en) loads++;
      if (ia.done_valid) seen_done = 1;
    end
    check_val("held_start_done_seen", seen_done, 1);
    ia.done_ready = 1;
    tick();
    check_val("held_start_idle", ia.busy, 0);
    check_val("held_start_loads", loads, 1);
    ia.start = 0;
    ia.done_ready = 0;
    tick();
    check_val("held_start_stay_idle", ia.busy, 0);
    $display("held start: load pulses=%0d", loads);

    // Reset in the middle of a run.
    ia.start = 1;
    tick();
    ia.start = 0;
    repeat (11) tick();
    check_val("mid_idx", ia.round_idx, 10);
    check_val("mid_round_en", ia.round_en, 1);
    #2 reset = 1;
    #1;
    check_all_zero("async_reset");
    tick();
    check_val("reset_held_done", ia.done_valid, 0);
    reset = 0;
    ia.start = 1;
    tick();
    check_val("restart_load", ia.load_en, 1);
    ia.start = 0;
    rcount = 0;
    seen_done = 0;
    for (int c = 0; c < 100 && !seen_done; c++) begin
      tick();
      if (ia.round_en) rcount++;
      if (ia.done_valid) seen_done = 1;
    end
    check_val("restart_done_seen", seen_done, 1);
    check_val("restart_rounds", rcount, 32);
    ia.done_ready = 1;
    tick();
    check_val("restart_ack", ia.busy, 0);
    ia.done_ready = 0;
    $display("reset mid-run: restart rounds=%0d", rcount);

    // 72-round instance: z sequence wraps after 62 rounds.
    ib.start = 1;
    tick();
    check_val("b_load", ib.load_en, 1);
    ib.start = 0;
    ib.done_ready = 1;
    for (int r = 0; r <= 62; r++) begin
      tick();
      zexp = zseq[61 - (r % 62)];
      check_val("b_idx", ib.round_idx, r);
      check_val("b_z", ib.z_bit, zexp);
    end
    check_val("b_z62", ib.z_bit, 1);
    seen_done = 0;
    for (int c = 0; c < 30 && !seen_done; c++) begin
      tick();
      if (!ib.busy) seen_done = 1;
    end
    check_val("b_back_idle", seen_done, 1);
    ib.done_ready = 0;
    $display("z wrap: 72-round run completed");

`ifdef SIMON_ROUND_ABORT_EN
    // Abort mid-run, then abort in IDLE and in LOAD.
    ia.start = 1;
    tick();
    ia.start = 0;
    repeat (8) tick();
    check_val("abort_pre_idx", ia.round_idx, 7);
    ia.abort = 1;
    tick();
    ia.abort = 0;
    check_all_zero("abort_run");
    seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (ia.done_valid) seen_done = 1;
    end
    check_val("abort_no_done", seen_done, 0);
    ia.abort = 1;
    tick();
    check_val("abort_idle_busy", ia.busy, 0);
    ia.start = 1;
    tick();
    check_val("abort_idle_start", ia.load_en, 1);
    ia.start = 0;
    tick();
    check_val("abort_in_load", ia.busy, 0);
    ia.abort = 0;
    $display("abort: run cancelled at round 7");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
